// File: rtl/fir_mac_scheduler.sv
// Channel arbiter and issue sequencer that time-shares one serial symmetric-FIR MAC between NCH
// channels. Optional build macro FIR_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
module fir_mac_scheduler #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TAPS    = 16,
    parameter int unsigned MAC_LAT = 2,
    parameter int unsigned CHW     = 2,
    parameter int unsigned IW      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   grant,
    output logic             busy,
    output logic             mac_vld,
    output logic [CHW-1:0]   mac_ch,
    output logic [IW-1:0]    tap_a_idx,
    output logic [IW-1:0]    tap_b_idx,
    output logic [IW-2:0]    coef_addr,
    output logic             acc_load,
    output logic             acc_last,
    output logic             out_vld,
    output logic [CHW-1:0]   out_ch
);

    localparam int unsigned   HALF    = TAPS / 2;
    localparam logic [IW-2:0] KLast   = (IW-1)'(HALF - 1);
    localparam logic [IW-1:0] TapLast = IW'(TAPS - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [IW-2:0]   k_q, k_d;
    logic [CHW-1:0]  ch_q, ch_d;

    logic            issue;
    logic            last_issue;
    logic            can_grant;
    logic            win_found;
    logic [CHW-1:0]  win_ch;

    assign issue      = (state_q == StRun) && en;
    assign last_issue = issue && (k_q == KLast);
    // A new sample may start only from idle or on the final issue of the current one,
    // which is what gives back-to-back samples without a bubble.
    assign can_grant  = en && rst_n && (|req) && win_found
                        && ((state_q == StIdle) || last_issue);

`ifdef FIR_SCHED_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_ch    = CHW'(i);
            end
        end
    end
`else
    logic [CHW-1:0] ptr_q, ptr_d;

    // ptr_q holds the first channel to consider: one past the last grant.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_ch    = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NCH)) begin
                idx = idx - int'(NCH);
            end
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_ch    = CHW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (can_grant) begin
            ptr_d = (win_ch == CHW'(NCH - 1)) ? '0 : win_ch + CHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign grant = can_grant ? (NCH'(1) << win_ch) : '0;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ch_d    = ch_q;
        if (issue) begin
            k_d = k_q + (IW-1)'(1);
        end
        if (last_issue) begin
            state_d = StIdle;
            k_d     = '0;
        end
        if (can_grant) begin
            state_d = StRun;
            k_d     = '0;
            ch_d    = win_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
        end
    end

    // Tags ride alongside the operands so strobes line up with the product at the accumulator.
    logic [MAC_LAT-1:0] tag_vld_q;
    logic [MAC_LAT-1:0] tag_first_q;
    logic [MAC_LAT-1:0] tag_last_q;
    logic [CHW-1:0]     tag_ch_q [MAC_LAT];
    logic               out_vld_q;
    logic [CHW-1:0]     out_ch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q   <= '0;
            tag_first_q <= '0;
            tag_last_q  <= '0;
            for (int i = 0; i < int'(MAC_LAT); i++) begin
                tag_ch_q[i] <= '0;
            end
            out_vld_q <= 1'b0;
            out_ch_q  <= '0;
        end else begin
            tag_vld_q[0]   <= issue;
            tag_first_q[0] <= issue && (k_q == '0);
            tag_last_q[0]  <= last_issue;
            tag_ch_q[0]    <= ch_q;
            for (int i = 1; i < int'(MAC_LAT); i++) begin
                tag_vld_q[i]   <= tag_vld_q[i-1];
                tag_first_q[i] <= tag_first_q[i-1];
                tag_last_q[i]  <= tag_last_q[i-1];
                tag_ch_q[i]    <= tag_ch_q[i-1];
            end
            out_vld_q <= tag_last_q[MAC_LAT-1];
            out_ch_q  <= tag_ch_q[MAC_LAT-1];
        end
    end

    assign acc_load  = tag_first_q[MAC_LAT-1];
    assign acc_last  = tag_last_q[MAC_LAT-1];
    assign out_vld   = out_vld_q;
    assign out_ch    = out_vld_q ? out_ch_q : '0;
    assign busy      = (state_q == StRun) || (|tag_vld_q) || out_vld_q;

    assign mac_vld   = issue;
    assign mac_ch    = issue ? ch_q : '0;
    assign tap_a_idx = issue ? {1'b0, k_q} : '0;
    assign tap_b_idx = issue ? (TapLast - {1'b0, k_q}) : '0;
    assign coef_addr = issue ? k_q : '0;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench: cycle-indexed expectation tables filled from the scheduling rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fir_mac_scheduler;

    localparam int NCH = 4, TAPS = 16, L = 2, CHW = 2, IW = 4, H = TAPS / 2, N = 5000;

    logic            clk, rst_n, en;
    logic [NCH-1:0]  req, grant;
    logic            busy, mac_vld, acc_load, acc_last, out_vld;
    logic [CHW-1:0]  mac_ch, out_ch;
    logic [IW-1:0]   tap_a_idx, tap_b_idx;
    logic [IW-2:0]   coef_addr;

    fir_mac_scheduler #(.NCH(NCH), .TAPS(TAPS), .MAC_LAT(L), .CHW(CHW), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .grant(grant), .busy(busy),
        .mac_vld(mac_vld), .mac_ch(mac_ch), .tap_a_idx(tap_a_idx), .tap_b_idx(tap_b_idx),
        .coef_addr(coef_addr), .acc_load(acc_load), .acc_last(acc_last),
        .out_vld(out_vld), .out_ch(out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;

    // Expected activity per absolute cycle.
    bit e_vld[N];  int e_ch[N];  int e_k[N];
    bit e_load[N]; bit e_last[N]; bit e_out[N]; int e_och[N];

    bit m_act;  int m_ch, m_k, m_ptr;  int last_rst = -1000;

    logic [NCH-1:0] s_grant;
    logic s_busy, s_vld, s_load, s_last, s_out;
    logic [31:0] s_ch, s_a, s_b, s_coef, s_och;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step(input bit r_n, input bit e, input logic [NCH-1:0] rq);
        bit issuing, is_last, xbusy;
        int win;
        logic [NCH-1:0] xgrant;
        @(posedge clk);
        #1;
        rst_n = r_n; en = e; req = rq;
        @(negedge clk);
        s_grant = grant; s_busy = busy; s_vld = mac_vld; s_ch = 32'(mac_ch);
        s_a = 32'(tap_a_idx); s_b = 32'(tap_b_idx); s_coef = 32'(coef_addr);
        s_load = acc_load; s_last = acc_last; s_out = out_vld; s_och = 32'(out_ch);

        issuing = 0; is_last = 0; win = -1; xgrant = '0;
        if (!r_n) begin
            for (int i = cyc; i < N; i++) begin
                e_vld[i] = 0; e_load[i] = 0; e_last[i] = 0; e_out[i] = 0;
            end
            m_act = 0; m_k = 0; m_ptr = 0; last_rst = cyc;
        end else begin
            issuing = m_act && e;
            is_last = issuing && (m_k == H - 1);
            if (issuing) begin
                e_vld[cyc] = 1; e_ch[cyc] = m_ch; e_k[cyc] = m_k;
                if (m_k == 0) e_load[cyc + L] = 1;
                if (is_last) begin
                    e_last[cyc + L] = 1;
                    e_out[cyc + L + 1] = 1;
                    e_och[cyc + L + 1] = m_ch;
                end
            end
            if (e && rq != 0 && (!m_act || is_last)) begin
                for (int i = 0; i < NCH; i++) begin
`ifdef FIR_SCHED_FIXED_PRIO_EN
                    int c = i;
`else
                    int c = (m_ptr + i) % NCH;
`endif
                    if (win < 0 && rq[c]) win = c;
                end
                xgrant = NCH'(1) << win;
            end
        end

        xbusy = m_act || e_out[cyc];
        for (int s = cyc - L; s < cyc; s++)
            if (s >= 0 && s > last_rst && e_vld[s]) xbusy = 1;

        chk("grant", 32'(s_grant), 32'(xgrant));
        chk("busy", 32'(s_busy), 32'(xbusy));
        chk("mac_vld", 32'(s_vld), 32'(e_vld[cyc]));
        chk("mac_ch", s_ch, e_vld[cyc] ? e_ch[cyc] : 0);
        chk("tap_a_idx", s_a, e_vld[cyc] ? e_k[cyc] : 0);
        chk("tap_b_idx", s_b, e_vld[cyc] ? TAPS - 1 - e_k[cyc] : 0);
        chk("coef_addr", s_coef, e_vld[cyc] ? e_k[cyc] : 0);
        chk("acc_load", 32'(s_load), 32'(e_load[cyc]));
        chk("acc_last", 32'(s_last), 32'(e_last[cyc]));
        chk("out_vld", 32'(s_out), 32'(e_out[cyc]));
        chk("out_ch", s_och, e_out[cyc] ? e_och[cyc] : 0);

        if (issuing) m_k++;
        if (is_last) m_act = 0;
        if (win >= 0) begin
            m_act = 1; m_ch = win; m_k = 0; m_ptr = (win + 1) % NCH;
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(0, 0, '0);
        step(0, 0, '0);
    endtask

    initial begin
        int nout;
        rst_n = 1'b1; en = 1'b0; req = '0;
        #1 rst_n = 1'b0;
        do_reset();

        // Single request on channel 2.
        step(1, 1, 4'b0100);
        chk("lit_single_grant", 32'(s_grant), 32'h4);
        for (int r = 1; r < 14; r++) begin
            step(1, 1, '0);
            case (r)
                1:  begin chk("lit_first_vld", 32'(s_vld), 1); chk("lit_first_tapb", s_b, 15); end
                3:  chk("lit_acc_load", 32'(s_load), 1);
                8:  begin chk("lit_last_tapa", s_a, 7); chk("lit_last_tapb", s_b, 8);
                          chk("lit_last_coef", s_coef, 7); end
                9:  chk("lit_vld_ends", 32'(s_vld), 0);
                10: chk("lit_acc_last", 32'(s_last), 1);
                11: begin chk("lit_out_vld", 32'(s_out), 1); chk("lit_out_ch", s_och, 2); end
                12: chk("lit_busy_clear", 32'(s_busy), 0);
                default: ;
            endcase
        end

        // All channels requesting.
        do_reset();
        for (int r = 0; r <= 40; r++) begin
            step(1, 1, 4'b1111);
            case (r)
                0:  chk("lit_all_g0", 32'(s_grant), 32'h1);
                8:  chk("lit_all_g8", 32'(s_grant), 32'h2);
                9:  chk("lit_all_nobubble", 32'(s_vld), 1);
                16: chk("lit_all_g16", 32'(s_grant), 32'h4);
                19: begin chk("lit_all_out19", 32'(s_out), 1); chk("lit_all_och19", s_och, 1); end
                24: chk("lit_all_g24", 32'(s_grant), 32'h8);
                32: chk("lit_all_g32", 32'(s_grant), 32'h1);
                35: chk("lit_all_och35", s_och, 3);
                default: ;
            endcase
        end

        // Same channel re-granted back to back.
        do_reset();
        for (int r = 0; r <= 20; r++) begin
            step(1, 1, 4'b0010);
            case (r)
                8:  chk("lit_rep_vld8", 32'(s_vld), 1);
                11: chk("lit_rep_load11", 32'(s_load), 1);
                16: chk("lit_rep_g16", 32'(s_grant), 32'h2);
                default: ;
            endcase
        end

        // Enable dropped for two cycles mid-sample.
        do_reset();
        step(1, 1, 4'b0001);
        for (int r = 1; r < 15; r++) begin
            step(1, !(r == 4 || r == 5), '0);
            case (r)
                4:  chk("lit_en_vld4", 32'(s_vld), 0);
                6:  chk("lit_en_tapa6", s_a, 3);
                10: chk("lit_en_tapa10", s_a, 7);
                13: chk("lit_en_out13", 32'(s_out), 1);
                default: ;
            endcase
        end

        // Reset mid-run discards the sample.
        do_reset();
        step(1, 1, 4'b0001);
        for (int r = 1; r < 5; r++) step(1, 1, '0);
        nout = 0;
        for (int r = 5; r < 25; r++) begin
            step((r < 5 || r > 6), 1, '0);
            if (s_out) nout++;
            if (r == 5) chk("lit_rst_busy", 32'(s_busy), 0);
        end
        chk("lit_rst_no_out", 32'(nout), 0);

        // Channels 1 and 3 competing.
        do_reset();
        for (int r = 0; r <= 20; r++) begin
            step(1, 1, 4'b1010);
            case (r)
                0:  chk("lit_pair_g0", 32'(s_grant), 32'h2);
`ifdef FIR_SCHED_FIXED_PRIO_EN
                8:  chk("lit_pair_g8", 32'(s_grant), 32'h2);
`else
                8:  chk("lit_pair_g8", 32'(s_grant), 32'h8);
`endif
                16: chk("lit_pair_g16", 32'(s_grant), 32'h2);
                default: ;
            endcase
        end

        // Randomized traffic with occasional enable drops and resets.
        for (int r = 0; r < 3000; r++) begin
            bit rr;
            rr = ($urandom_range(0, 199) != 0);
            step(rr, ($urandom_range(0, 9) != 0), NCH'($urandom & $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
